// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: MIPS-style main/ALU decoder for the Decode stage, the
// D->E, E->M and M->W control-register chain, and next-PC selection with a
// younger-instruction kill request. Branches resolve either in Decode or in
// Memory depending on BR_STAGE.
//
// This block has no valid/ready handshakes. Pipeline movement is governed
// only by stall_e (hold E, M and W) and by bubbles. A bubble is all-zero
// controls and is loaded into E on flush_e or on a taken Memory-stage
// branch. A bubble wins over a stall.
module pipeline_ctrl #(
   parameter int ALUCTRL_W = 4,
   parameter int BR_STAGE  = 0,
   parameter int HAS_HILO  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   // Decode-stage instruction fields and compare results
   input  logic [5:0]           opcode_d,
   input  logic [5:0]           funct_d,
   input  logic                 equal_d,
   input  logic                 zero_m,
   // Pipeline control
   input  logic                 stall_e,
   input  logic                 flush_e,
   // Combinational Decode controls
   output logic                 regwrite_d,
   output logic                 memtoreg_d,
   output logic                 memwrite_d,
   output logic                 branch_d,
   output logic                 alusrc_d,
   output logic                 jump_d,
   output logic                 jr_d,
   output logic                 illegal_d,
   output logic [1:0]           regdst_d,
   // Execute controls
   output logic [ALUCTRL_W-1:0] alucontrol_e,
   output logic                 regwrite_e,
   output logic                 memtoreg_e,
   output logic                 memwrite_e,
   output logic                 alusrc_e,
   output logic                 hilowrite_e,
   // Memory and Writeback controls
   output logic                 regwrite_m,
   output logic                 memtoreg_m,
   output logic                 memwrite_m,
   output logic                 regwrite_w,
   output logic                 memtoreg_w,
   // Next-PC select and kill request
   output logic [1:0]           pcsrc,
   output logic                 flush_br
);

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   // R-type function codes
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_MULT = 6'b011000;
   localparam logic [5:0] FN_MFHI = 6'b010000;
   localparam logic [5:0] FN_MFLO = 6'b010010;

   // ALU control codes. The mult code only fits when ALUCTRL_W >= 4.
   localparam logic [ALUCTRL_W-1:0] ALU_AND  = ALUCTRL_W'(0);
   localparam logic [ALUCTRL_W-1:0] ALU_OR   = ALUCTRL_W'(1);
   localparam logic [ALUCTRL_W-1:0] ALU_ADD  = ALUCTRL_W'(2);
   localparam logic [ALUCTRL_W-1:0] ALU_SUB  = ALUCTRL_W'(6);
   localparam logic [ALUCTRL_W-1:0] ALU_SLT  = ALUCTRL_W'(7);
   localparam logic [ALUCTRL_W-1:0] ALU_MULT = ALUCTRL_W'(8);

   // Register-destination and next-PC encodings
   localparam logic [1:0] RD_RT  = 2'b00;
   localparam logic [1:0] RD_RD  = 2'b01;
   localparam logic [1:0] RD_R31 = 2'b10;

   localparam logic [1:0] PC_SEQ    = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;
   localparam logic [1:0] PC_REG    = 2'b11;

   localparam bit BR_IN_M = (BR_STAGE == 1);
   localparam bit HILO_EN = (HAS_HILO != 0);

   // Control bundles carried down the pipeline. branch/is_bne ride along
   // only when branches resolve in Memory; otherwise they stay zero.
   typedef struct packed {
      logic                 regwrite;
      logic                 memtoreg;
      logic                 memwrite;
      logic                 alusrc;
      logic                 hilowrite;
      logic                 branch;
      logic                 is_bne;
      logic [ALUCTRL_W-1:0] alu;
   } e_ctrl_t;

   typedef struct packed {
      logic regwrite;
      logic memtoreg;
      logic memwrite;
      logic branch;
      logic is_bne;
   } m_ctrl_t;

   typedef struct packed {
      logic regwrite;
      logic memtoreg;
   } w_ctrl_t;

   logic [ALUCTRL_W-1:0] alucontrol_dec;
   logic                 hilowrite_dec;
   logic                 is_bne_dec;
   logic                 taken_d;
   logic                 taken_m;

   e_ctrl_t e_ctrl_q, e_ctrl_d;
   m_ctrl_t m_ctrl_q, m_ctrl_d;
   w_ctrl_t w_ctrl_q, w_ctrl_d;

   // Main and ALU decode. Every output starts at zero, and an illegal
   // encoding only raises illegal_d, so it can never enable a write.
   always_comb begin
      regwrite_d     = 1'b0;
      memtoreg_d     = 1'b0;
      memwrite_d     = 1'b0;
      branch_d       = 1'b0;
      alusrc_d       = 1'b0;
      jump_d         = 1'b0;
      jr_d           = 1'b0;
      illegal_d      = 1'b0;
      regdst_d       = RD_RT;
      alucontrol_dec = ALU_AND;
      hilowrite_dec  = 1'b0;
      is_bne_dec     = 1'b0;
      case (opcode_d)
         OP_RTYPE: begin
            case (funct_d)
               FN_ADD:  begin regwrite_d = 1'b1; regdst_d = RD_RD; alucontrol_dec = ALU_ADD; end
               FN_SUB:  begin regwrite_d = 1'b1; regdst_d = RD_RD; alucontrol_dec = ALU_SUB; end
               FN_AND:  begin regwrite_d = 1'b1; regdst_d = RD_RD; alucontrol_dec = ALU_AND; end
               FN_OR:   begin regwrite_d = 1'b1; regdst_d = RD_RD; alucontrol_dec = ALU_OR;  end
               FN_SLT:  begin regwrite_d = 1'b1; regdst_d = RD_RD; alucontrol_dec = ALU_SLT; end
               FN_JR:   jr_d = 1'b1;
               FN_MULT: begin
                  if (HILO_EN) begin
                     hilowrite_dec  = 1'b1;
                     alucontrol_dec = ALU_MULT;
                  end else begin
                     illegal_d = 1'b1;
                  end
               end
               FN_MFHI, FN_MFLO: begin
                  if (HILO_EN) begin
                     regwrite_d = 1'b1;
                     regdst_d   = RD_RD;
                  end else begin
                     illegal_d = 1'b1;
                  end
               end
               default: illegal_d = 1'b1;
            endcase
         end
         OP_LW:   begin regwrite_d = 1'b1; memtoreg_d = 1'b1; alusrc_d = 1'b1; alucontrol_dec = ALU_ADD; end
         OP_SW:   begin memwrite_d = 1'b1; alusrc_d = 1'b1; alucontrol_dec = ALU_ADD; end
         OP_BEQ:  begin branch_d = 1'b1; alucontrol_dec = ALU_SUB; end
         OP_BNE:  begin branch_d = 1'b1; is_bne_dec = 1'b1; alucontrol_dec = ALU_SUB; end
         OP_ADDI: begin regwrite_d = 1'b1; alusrc_d = 1'b1; alucontrol_dec = ALU_ADD; end
         OP_J:    jump_d = 1'b1;
         OP_JAL:  begin jump_d = 1'b1; regwrite_d = 1'b1; regdst_d = RD_R31; end
         default: illegal_d = 1'b1;
      endcase
   end

   // Branch resolution: only one of the two terms can be live for a given BR_STAGE.
   always_comb begin
      taken_d = ~BR_IN_M & branch_d & (equal_d ^ is_bne_dec);
      taken_m =  BR_IN_M & m_ctrl_q.branch & (zero_m ^ m_ctrl_q.is_bne);
   end

   // Next-PC priority: Memory branch, then jr, then jump, then Decode branch.
   always_comb begin
      pcsrc    = PC_SEQ;
      flush_br = 1'b0;
      if (taken_m) begin
         pcsrc    = PC_BRANCH;
         flush_br = 1'b1;
      end else if (jr_d) begin
         pcsrc    = PC_REG;
         flush_br = 1'b1;
      end else if (jump_d) begin
         pcsrc    = PC_JUMP;
         flush_br = 1'b1;
      end else if (taken_d) begin
         pcsrc    = PC_BRANCH;
         flush_br = 1'b1;
      end
   end

   // Next values for the E, M and W control registers. A bubble into E beats stall.
   always_comb begin
      e_ctrl_d = e_ctrl_q;
      m_ctrl_d = m_ctrl_q;
      w_ctrl_d = w_ctrl_q;
      if (flush_e || taken_m) begin
         e_ctrl_d = '0;
      end else if (!stall_e) begin
         e_ctrl_d.regwrite  = regwrite_d;
         e_ctrl_d.memtoreg  = memtoreg_d;
         e_ctrl_d.memwrite  = memwrite_d;
         e_ctrl_d.alusrc    = alusrc_d;
         e_ctrl_d.hilowrite = hilowrite_dec;
         e_ctrl_d.branch    = BR_IN_M & branch_d;
         e_ctrl_d.is_bne    = BR_IN_M & is_bne_dec;
         e_ctrl_d.alu       = alucontrol_dec;
      end
      if (!stall_e) begin
         m_ctrl_d.regwrite = e_ctrl_q.regwrite;
         m_ctrl_d.memtoreg = e_ctrl_q.memtoreg;
         m_ctrl_d.memwrite = e_ctrl_q.memwrite;
         m_ctrl_d.branch   = e_ctrl_q.branch;
         m_ctrl_d.is_bne   = e_ctrl_q.is_bne;
         w_ctrl_d.regwrite = m_ctrl_q.regwrite;
         w_ctrl_d.memtoreg = m_ctrl_q.memtoreg;
      end
   end

   // Control registers; reset clears every in-flight control at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_ctrl_q <= '0;
         m_ctrl_q <= '0;
         w_ctrl_q <= '0;
      end else begin
         e_ctrl_q <= e_ctrl_d;
         m_ctrl_q <= m_ctrl_d;
         w_ctrl_q <= w_ctrl_d;
      end
   end

   // Registered controls out to the datapath.
   always_comb begin
      alucontrol_e = e_ctrl_q.alu;
      regwrite_e   = e_ctrl_q.regwrite;
      memtoreg_e   = e_ctrl_q.memtoreg;
      memwrite_e   = e_ctrl_q.memwrite;
      alusrc_e     = e_ctrl_q.alusrc;
      hilowrite_e  = e_ctrl_q.hilowrite;
      regwrite_m   = m_ctrl_q.regwrite;
      memtoreg_m   = m_ctrl_q.memtoreg;
      memwrite_m   = m_ctrl_q.memwrite;
      regwrite_w   = w_ctrl_q.regwrite;
      memtoreg_w   = w_ctrl_q.memtoreg;
   end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter ALUCTRL_W, default 4: width of ALU control code; SHALL be >= 3, codes below 8 SHALL fit in 3 LSBs.
REQ-002 Parameter BR_STAGE, default 0: 0 resolves branches in Decode, 1 resolves them in Memory.
REQ-003 Parameter HAS_HILO, default 1: 1 decodes mult/mfhi/mflo; 0 SHALL treat them as illegal.
REQ-004 clk  in  1  sole clock; all registers update on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 opcode_d, funct_d  in  6 each  instruction fields in Decode.
REQ-007 equal_d  in  1  register-compare result in Decode; zero_m  in  1  ALU zero in Memory.
REQ-008 stall_e  in  1  hold the E, M and W control registers; flush_e  in  1  load a bubble into E.
REQ-009 regwrite_d, memtoreg_d, memwrite_d, branch_d, alusrc_d, jump_d, jr_d, illegal_d  out  1 each  combinational Decode controls.
REQ-010 regdst_d  out  2  00 rt, 01 rd, 10 register 31.
REQ-011 alucontrol_e  out  ALUCTRL_W; regwrite_e, memtoreg_e, memwrite_e, alusrc_e, hilowrite_e  out  1 each  Execute controls.
REQ-012 regwrite_m, memtoreg_m, memwrite_m  out  1 each; regwrite_w, memtoreg_w  out  1 each.
REQ-013 pcsrc  out  2  00 pc+4, 01 branch target, 10 jump target, 11 register (jr); flush_br  out  1  younger-instruction kill request.

Function
REQ-014 Decode table SHALL be: R-type 000000 (funct add 100000, sub 100010, and 100100, or 100101, slt 101010, jr 001000, mult 011000, mfhi 010000, mflo 010010); lw 100011; sw 101011; beq 000100; bne 000101; addi 001000; j 000010; jal 000011.
REQ-015 ALU codes SHALL be: and 0, or 1, add 2, sub 6, slt 7, mult 8; lw/sw/addi use add; beq/bne use sub.
REQ-016 jal SHALL assert regwrite_d, regdst_d=10, jump_d; jr SHALL assert jr_d with regwrite_d=0.
REQ-017 Any other opcode/funct SHALL assert illegal_d and drive every write/enable output of that instruction to 0.
REQ-018 D->E register SHALL load Decode controls each cycle; E->M and M->W SHALL shift; all three SHALL hold when stall_e=1.
REQ-019 flush_e=1 SHALL load zeros into E regardless of stall_e (flush wins); M and W SHALL still shift unless stall_e=1.
REQ-020 BR_STAGE=0: taken = branch_d & (equal_d XOR is_bne_d); pcsrc=01 and flush_br=1 in the same cycle.
REQ-021 BR_STAGE=1: branch and is_bne SHALL pipeline to M; taken = branch_m & (zero_m XOR is_bne_m); flush_br=1 and, that cycle, E SHALL be bubbled.
REQ-022 pcsrc priority SHALL be: taken M-branch (BR_STAGE=1) > jr_d > jump_d > taken D-branch > 00; jump/jr SHALL assert flush_br.
REQ-023 Latency: a Decode control SHALL appear at _e 1 cycle later, _m 2, _w 3, absent stall/flush.
REQ-024 hilowrite_e SHALL be 1 only for mult; mfhi/mflo SHALL write rd.

Reset
REQ-025 rst_n=0 SHALL immediately clear all E, M, W control registers to 0, giving pcsrc=00, flush_br=0 from registered terms.
REQ-026 Reset asserted mid-pipeline SHALL discard all in-flight controls; first post-release instruction SHALL reach W after 3 edges.

Verification
REQ-027 lw (100011) at D, no stall -> regwrite_e=memtoreg_e=1 next edge; regwrite_w=memtoreg_w=1 after 3 edges.
REQ-028 BR_STAGE=0, bne, equal_d=0 -> pcsrc=01, flush_br=1 same cycle; equal_d=1 -> pcsrc=00.
REQ-029 BR_STAGE=1, beq then j at D when beq at M with zero_m=1 -> pcsrc=01 (branch wins), E bubbled.
REQ-030 sw at E, stall_e=1 for 2 cycles -> memwrite_e held 1, memwrite_m stays prior value; flush_e with stall_e -> all _e=0.
REQ-031 opcode 111111 -> illegal_d=1, regwrite_d=memwrite_d=0, alucontrol_e=0 next edge; HAS_HILO=0 mult -> illegal_d=1.
REQ-032 rst_n low for 1 ns mid-cycle with add in M -> regwrite_m=0 immediately, no edge required.
